// File: rtl/hdr_merge_five_if.sv
// Handshake bundle between the HDR weight stage, the exposure merge and the tone-map stage.
// master drives pixel/weight sets and out_ready; slave is the merge block.
interface hdr_merge_five_if #(
    parameter int N   = 5,
    parameter int W_W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   pixel_high;
    logic [N-1:0]   pixel_mid;
    logic [N-1:0]   pixel_low;
    logic [W_W-1:0] w_high;
    logic [W_W-1:0] w_mid;
    logic [W_W-1:0] w_low;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   pixel_out;
    logic           busy;

    modport master (
        output in_valid, pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low, out_ready,
        input  in_ready, out_valid, pixel_out, busy
    );

    modport slave (
        input  in_valid, pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low, out_ready,
        output in_ready, out_valid, pixel_out, busy
    );
endinterface

// File: rtl/hdr_merge_five.sv
// Fuses three exposures into round(sum(w*p)/sum(w)) with a restoring divider, one quotient bit per cycle.
// Latency: N+1 edges after acceptance (1 edge when all weights are zero); one set per N+3 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module hdr_merge_five #(
    parameter int N   = 5,
    parameter int W_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hdr_merge_five_if.slave  bus
);
    localparam int NUM_W = N + W_W + 2;
    localparam int DEN_W = W_W + 2;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [N-1:0]     p_h, p_m, p_l;
    logic [W_W-1:0]   w_h, w_m, w_l;
    logic [NUM_W-1:0] numr_r;      // rounded numerator, then the running remainder during DIV
    logic [DEN_W-1:0] den_r;
    logic             sat_r;
    logic [N-1:0]     quot;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     pix_out_r;
    logic             out_vld_r;

    logic [NUM_W-1:0] num_c, numr_c, trial_c;
    logic [DEN_W-1:0] den_c;
    logic             sat_c, ge_c;
    logic [CNT_W-1:0] k_c;
    logic [N-1:0]     quot_nxt;

    always_comb begin
        num_c  = NUM_W'(p_h) * NUM_W'(w_h) + NUM_W'(p_m) * NUM_W'(w_m) + NUM_W'(p_l) * NUM_W'(w_l);
        den_c  = DEN_W'(w_h) + DEN_W'(w_m) + DEN_W'(w_l);
        numr_c = num_c + NUM_W'(den_c >> 1);
        // quotient would not fit in N bits iff numr >= den * 2^N; one spare bit keeps the compare exact
        sat_c  = ({1'b0, numr_c} >= {1'b0, den_c, {N{1'b0}}});
    end

    always_comb begin
        k_c      = LAST_BIT - cnt;
        trial_c  = NUM_W'(den_r) << k_c;
        ge_c     = (numr_r >= trial_c);
        quot_nxt = quot;
        if (ge_c) begin
            quot_nxt = quot | (N'(1) << k_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            p_h       <= '0;
            p_m       <= '0;
            p_l       <= '0;
            w_h       <= '0;
            w_m       <= '0;
            w_l       <= '0;
            numr_r    <= '0;
            den_r     <= '0;
            sat_r     <= 1'b0;
            quot      <= '0;
            cnt       <= '0;
            pix_out_r <= '0;
            out_vld_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        p_h   <= bus.pixel_high;
                        p_m   <= bus.pixel_mid;
                        p_l   <= bus.pixel_low;
                        w_h   <= bus.w_high;
                        w_m   <= bus.w_mid;
                        w_l   <= bus.w_low;
                        state <= MULT;
                    end
                end
                MULT: begin
                    numr_r <= numr_c;
                    den_r  <= den_c;
                    sat_r  <= sat_c;
                    quot   <= '0;
                    cnt    <= '0;
                    // all-zero weights carry no information; fall back to the mid exposure
                    if (den_c == '0) begin
                        pix_out_r <= p_m;
                        out_vld_r <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (ge_c) begin
                        numr_r <= numr_r - trial_c;
                    end
                    quot <= quot_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        pix_out_r <= sat_r ? {N{1'b1}} : quot_nxt;
                        out_vld_r <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_vld_r <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_vld_r;
    assign bus.pixel_out = pix_out_r;
endmodule

// File: tb/tb_hdr_merge_five.sv
// Scoreboarded bench for hdr_merge_five: directed corner sets, backpressure, abort-by-reset, then random sets.
module tb_hdr_merge_five;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdr_merge_five_if #(.N(5), .W_W(8)) bus ();
    hdr_merge_five #(.N(5), .W_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   auto_rdy = 1'b0;
    bit   prev_vld = 1'b0;
    bit   prev_acc = 1'b0;
    int   prev_pix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endfunction

    // Reference: rounded weighted mean, mid pixel when weights are all zero, clamp to 31.
    function automatic int model(int ph, int pm, int pl, int wh, int wm, int wl);
        int num, den, r;
        den = wh + wm + wl;
        if (den == 0) return pm;
        num = ph * wh + pm * wm + pl * wl;
        r   = (num + den / 2) / den;
        return (r > 31) ? 31 : r;
    endfunction

    // Monitor: new results are popped on the rising of out_valid; held results must stay put.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pixel_out", int'(bus.pixel_out), e.val);
                    chk("latency", cyc, e.due);
                end
            end else if (prev_vld && !prev_acc) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_pixel", int'(bus.pixel_out), prev_pix);
            end
        end
        prev_vld = rst_n && bus.out_valid;
        prev_acc = bus.out_ready;
        prev_pix = int'(bus.pixel_out);
    end

    // Random downstream readiness, changed just after each edge so the monitor sees a settled value.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input int ph, input int pm, input int pl, input int wh, input int wm, input int wl);
        bit   done;
        exp_t e;
        done = 1'b0;
        bus.pixel_high = 5'(ph);
        bus.pixel_mid  = 5'(pm);
        bus.pixel_low  = 5'(pl);
        bus.w_high     = 8'(wh);
        bus.w_mid      = 8'(wm);
        bus.w_low      = 8'(wl);
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.in_ready) begin
                e.val = model(ph, pm, pl, wh, wm, wl);
                e.due = cyc + 1 + (((wh + wm + wl) == 0) ? 1 : 6);
                sb.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
        bus.in_valid   = 1'b0;
        bus.pixel_high = 5'($urandom);
        bus.pixel_mid  = 5'($urandom);
        bus.pixel_low  = 5'($urandom);
        bus.w_high     = 8'($urandom);
        bus.w_mid      = 8'($urandom);
        bus.w_low      = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (sb.size() == 0 && bus.in_ready && !bus.out_valid) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.pixel_high = 5'd10;
        bus.pixel_mid  = 5'd20;
        bus.pixel_low  = 5'd30;
        bus.w_high     = 8'd11;
        bus.w_mid      = 8'd12;
        bus.w_low      = 8'd2;

        // Reset held with in_valid asserted: nothing may be accepted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_pixel_out", int'(bus.pixel_out), 0);
            chk("rst_in_ready", int'(bus.in_ready), 1);
            chk("rst_busy", int'(bus.busy), 0);
        end
        rst_n = 1'b1;

        send(10, 20, 30, 11, 12, 2);
        wait_idle();
        send(7, 7, 7, 8, 8, 8);
        wait_idle();
        send(31, 31, 31, 1, 1, 1);
        wait_idle();
        send(0, 0, 0, 1, 1, 1);
        wait_idle();
        send(5, 19, 27, 0, 0, 0);
        wait_idle();
        send(31, 0, 31, 255, 255, 255);
        wait_idle();

        // Backpressure: result must hold while extra sets are offered and ignored.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        send(3, 17, 29, 40, 200, 9);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        chk("bp_valid_seen", int'(bus.out_valid), 1);
        repeat (10) begin
            bus.in_valid   = 1'b1;
            bus.pixel_high = 5'($urandom);
            bus.w_high     = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_busy", int'(bus.busy), 1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_released_valid", int'(bus.out_valid), 0);
        chk("bp_released_ready", int'(bus.in_ready), 1);
        bus.out_ready = 1'b1;

        // Abort in the middle of DIV: no result, and the next set is unaffected.
        send(12, 25, 3, 100, 50, 60);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(10, 20, 30, 11, 12, 2);
        wait_idle();

        // Random sets with random downstream readiness.
        auto_rdy = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int wh, wm, wl;
            if ($urandom_range(0, 7) == 0) begin
                wh = 0; wm = 0; wl = 0;
            end else begin
                wh = $urandom_range(0, 255);
                wm = $urandom_range(0, 255);
                wl = $urandom_range(0, 255);
            end
            send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), wh, wm, wl);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
